// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-length decode and GF(2^8) helper
//
// Key-length encoding, Nk/Nr lookup per key length, xtime, and the
// key-scheduler FSM state type. Imported by aes_key_scheduler.
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128  = 2'b00;
    localparam logic [1:0] KEY_LEN_192  = 2'b01;
    localparam logic [1:0] KEY_LEN_256  = 2'b10;
    localparam logic [1:0] KEY_LEN_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EXPAND = 2'd2
    } ks_state_e;

    // Key length in 32-bit words; 0 marks the reserved encoding.
    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: nk_of = 4'd4;
            KEY_LEN_192: nk_of = 4'd6;
            KEY_LEN_256: nk_of = 4'd8;
            default:     nk_of = 4'd0;
        endcase
    endfunction

    // Number of rounds.
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: nr_of = 4'd10;
            KEY_LEN_192: nr_of = 4'd12;
            KEY_LEN_256: nr_of = 4'd14;
            default:     nr_of = 4'd0;
        endcase
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - four parallel AES S-box lookups (SubWord)
//
// Ports:
//   word_i  [31:0]  input word
//   word_o  [31:0]  each byte replaced by its S-box image
module aes_subword (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    // Byte x lives at bits [2047-8x -: 8], i.e. offset {~x, 3'b000} from bit 0.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            word_o[8*b +: 8] = SBOX_FLAT[{~word_i[8*b +: 8], 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/aes_key_scheduler.sv
// rtl/aes_key_scheduler.sv - AES-128/192/256 key expansion with registered round-key read port
//
// Optional feature macro: AES_KEY_SCHED_INV_READ_EN (adds rd_inv for
// decryption-order reads).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, key_in,      expansion request; key_in left-justified (w[0] in MSBs)
//   key_len             00=128, 01=192, 10=256, 11 reserved
//   busy, done, err     busy in LOAD/EXPAND; done/err single-cycle pulses
//   key_valid           stored round keys are complete and readable
//   rd_en, rd_round     round-key read request and round index
//   rd_inv              (macro only) read round Nr - rd_round
//   rd_valid, rd_key    read response one cycle after rd_en
module aes_key_scheduler
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [32*MAX_NK-1:0]  key_in,
    input  logic [1:0]            key_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  key_valid,
    input  logic                  rd_en,
    input  logic [3:0]            rd_round,
`ifdef AES_KEY_SCHED_INV_READ_EN
    input  logic                  rd_inv,
`endif
    output logic                  rd_valid,
    output logic [127:0]          rd_key
);

    localparam int NWORDS = 4 * (MAX_NK + 7);
    localparam int IW     = $clog2(NWORDS);
    localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

    ks_state_e      state_q;
    logic [1:0]     key_len_q;
    logic [IW-1:0]  i_q;
    logic [3:0]     j_q;          // i mod Nk, tracked incrementally
    logic [7:0]     rcon_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic           key_valid_q;
    logic           rd_valid_q;
    logic [127:0]   rd_key_q;
    logic [31:0]    w_q [NWORDS];

    logic [3:0]     nk_cur;
    logic [3:0]     nr_cur;
    logic [3:0]     req_nk;
    logic           reject;
    logic [IW-1:0]  last_idx;
    logic [31:0]    prev_word;
    logic [31:0]    back_word;
    logic [31:0]    sub_in;
    logic [31:0]    sub_out;
    logic [31:0]    new_word_d;
    logic           rd_ok;
    logic [3:0]     eff_round;
    logic [IW-1:0]  rd_base;
    logic [127:0]   rd_key_d;

    // Nk/Nr always come from the length latched at start, never the live input.
    assign nk_cur   = nk_of(key_len_q);
    assign nr_cur   = nr_of(key_len_q);
    assign req_nk   = nk_of(key_len);
    assign reject   = (key_len == KEY_LEN_RSVD) || (req_nk > MAX_NK_L);
    // 4*(Nr+1)-1 == 4*Nr+3
    assign last_idx = IW'({nr_cur, 2'b11});

    assign prev_word = w_q[i_q - IW'(1)];
    assign back_word = w_q[i_q - IW'(nk_cur)];
    assign sub_in    = (j_q == 4'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_subword u_subword (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        new_word_d = back_word ^ prev_word;
        if (j_q == 4'd0) begin
            new_word_d = back_word ^ sub_out ^ {rcon_q, 24'h000000};
        end else if ((nk_cur == 4'd8) && (j_q == 4'd4)) begin
            new_word_d = back_word ^ sub_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_len_q   <= KEY_LEN_128;
            i_q         <= '0;
            j_q         <= '0;
            rcon_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (reject) begin
                            err_q <= 1'b1;
                        end else begin
                            key_len_q <= key_len;
                            busy_q    <= 1'b1;
                            state_q   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    key_valid_q <= 1'b0;
                    i_q         <= IW'(nk_cur);
                    j_q         <= 4'd0;
                    rcon_q      <= 8'h01;
                    state_q     <= ST_EXPAND;
                end
                ST_EXPAND: begin
                    if (j_q == 4'd0) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    j_q <= (j_q == nk_cur - 4'd1) ? 4'd0 : j_q + 4'd1;
                    if (i_q == last_idx) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        key_valid_q <= 1'b1;
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Word storage carries no reset; key_valid gates every read instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            for (int k = 0; k < MAX_NK; k++) begin
                if (4'(k) < nk_cur) begin
                    w_q[k] <= key_in[32*(MAX_NK-k)-1 -: 32];
                end
            end
        end else if (state_q == ST_EXPAND) begin
            w_q[i_q] <= new_word_d;
        end
    end

    // Range check happens on the requested index, before any inversion.
    always_comb begin
        rd_ok     = key_valid_q && !busy_q && (rd_round <= nr_cur);
        eff_round = rd_round;
`ifdef AES_KEY_SCHED_INV_READ_EN
        if (rd_inv) begin
            eff_round = nr_cur - rd_round;
        end
`endif
        rd_base  = IW'({eff_round, 2'b00});
        rd_key_d = '0;
        if (rd_ok) begin
            rd_key_d = {w_q[rd_base], w_q[rd_base + IW'(1)],
                        w_q[rd_base + IW'(2)], w_q[rd_base + IW'(3)]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_key_q   <= '0;
        end else begin
            rd_valid_q <= rd_en;
            rd_key_q   <= rd_en ? rd_key_d : '0;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign key_valid = key_valid_q;
    assign rd_valid  = rd_valid_q;
    assign rd_key    = rd_key_q;

endmodule

// File: doc/aes_key_scheduler.md
AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, giving the largest supported key length in 32-bit words (legal 4, 6, 8).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, a request to expand key_in.
REQ-005 SHALL have port key_in, input, 32*MAX_NK bits, the cipher key left-justified; the MSB word is w[0], and unused low words are ignored.
REQ-006 SHALL have port key_len, input, 2 bits, with encoding 00 = 128, 01 = 192, 10 = 256, and 11 reserved.
REQ-007 SHALL have port busy, output, 1 bit, high while in LOAD or EXPAND.
REQ-008 SHALL have port done, output, 1 bit, a one-cycle pulse at expansion completion.
REQ-009 SHALL have port err, output, 1 bit, a one-cycle pulse when start is rejected.
REQ-010 SHALL have port key_valid, output, 1 bit, high while stored round keys are complete.
REQ-011 SHALL have port rd_en, input, 1 bit, a round-key read request.
REQ-012 SHALL have port rd_round, input, 4 bits, the round index 0..Nr.
REQ-013 SHALL have port rd_valid, output, 1 bit, pulsing one cycle after rd_en.
REQ-014 SHALL have port rd_key, output, 128 bits, the round key words w[4r]..w[4r+3], MSB first.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> EXPAND -> IDLE.
- start is sampled only in IDLE; start in any other state is ignored.
REQ-016 SHALL pulse err, stay in IDLE and keep key_valid and the stored keys unchanged when start has key_len = 11 or a length above MAX_NK words.
REQ-017 SHALL do the following on the LOAD edge:
- store Nk words of key_in;
- clear key_valid;
- set word index i = Nk;
- set rcon = 0x01.
REQ-018 SHALL compute and store exactly one word w[i] per EXPAND cycle, until i = 4*(Nr+1)-1.
REQ-019 SHALL compute w[i] by these rules:
- i mod Nk = 0: w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}, then rcon = xtime(rcon) (x2, xor 0x1b on carry);
- Nk = 8 and i mod 8 = 4: w[i-8] ^ SubWord(w[i-1]);
- otherwise: w[i-Nk] ^ w[i-1].
REQ-020 SHALL use W = 4*(Nr+1)-Nk expansion cycles, i.e. 40, 46 or 52, with Nr = 10, 12 or 14.
REQ-021 SHALL raise done and key_valid on the edge writing the last word, which is edge W+1 after the start-sampling edge, and SHALL return to IDLE on that edge.
REQ-022 SHALL hold key_valid high until the next accepted start or reset.
REQ-023 SHALL register reads:
- rd_en at edge n gives rd_valid and rd_key at edge n+1;
- rd_key = 0 if key_valid is low or rd_round > Nr;
- reads while busy return 0.
REQ-024 SHALL keep key_len and Nk latched at start for the whole operation and for later reads.

Reset
REQ-025 SHALL, on rst_n low, immediately and regardless of state:
- set state to IDLE;
- set busy, done, err, key_valid, rd_valid and rd_key to 0;
- set i and rcon to 0.
REQ-026 SHALL require reset mid-EXPAND to abort the operation, after which the stored words need not be cleared but are never readable (key_valid = 0).

Configuration
REQ-027 SHALL, with macro AES_KEY_SCHED_INV_READ_EN defined:
- add input rd_inv (1 bit);
- when rd_inv = 1, return round Nr - rd_round, giving decryption order;
- apply the range check of REQ-023 before the mapping.
REQ-028 SHALL, without AES_KEY_SCHED_INV_READ_EN, have no rd_inv port and use direct indexing only.

Structure
REQ-029 SHALL take the following from shared package aes_pkg:
- the key_len encoding constants;
- Nk and Nr per key length;
- the xtime function.
REQ-030 SHALL instantiate sub-module aes_subword (four S-box lookups, combinational), the only S-box instance in the block.
REQ-031 SHALL store 4*(MAX_NK+7) 32-bit words in a register array.

Verification
REQ-032 SHALL verify the 128-bit FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c -> done at edge 41, and round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 SHALL verify the 192-bit vector: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done at edge 47, and w[51] = 01002202.
REQ-034 SHALL verify the 256-bit vector: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done at edge 53, and round 14 = fe4890d1e6188d0b046df344706c631e.
REQ-035 SHALL verify rejection: key_len = 11 -> err for one cycle, busy stays 0, and a prior valid key is still readable.
REQ-036 SHALL verify reset mid-operation:
- rst_n low at edge 20 of a 256-bit run -> all outputs 0 and key_valid 0;
- a restarted 128-bit run then completes correctly.
REQ-037 SHALL verify read bounds: rd_round = 15 after a 128-bit run -> rd_key = 0; and with AES_KEY_SCHED_INV_READ_EN, rd_inv = 1 with rd_round = 0 returns round 10.
